// File: rtl/decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared widths, types and the binary-to-one-hot helper for the
//                streaming 3x8 decoder.
//                  IN_W_DEF  - default code width
//                  OUT_W_DEF - one-hot width, always 1 << IN_W_DEF
//                  CNT_W_DEF - default drop counter width
//                  code_t    - binary code type
//                  onehot_t  - decoded one-hot word type
//                  decode()  - code_t -> onehot_t
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 1 << IN_W_DEF;
    localparam int CNT_W_DEF = 8;

    typedef logic [IN_W_DEF-1:0]  code_t;
    typedef logic [OUT_W_DEF-1:0] onehot_t;

    // Every code is in range because OUT_W_DEF == 2**IN_W_DEF.
    function automatic onehot_t decode(input code_t code);
        onehot_t w_word;
        w_word       = '0;
        w_word[code] = 1'b1;
        return w_word;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/skid_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : skid_buf
//  Description : Two-entry valid/ready skid buffer. One output register plus
//                one skid entry; sustains a transfer every cycle under
//                backpressure while keeping in_ready registered.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - upstream handshake (in_ready registered)
//                in_data [WIDTH]     - upstream payload
//                out_valid/out_ready - downstream handshake
//                out_data [WIDTH]    - registered payload, zero when idle
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;

    logic w_accept;
    logic w_load;

    assign w_accept = in_valid & r_in_ready;
    // Output register can take a new word when it is empty or draining.
    assign w_load   = ~r_out_valid | out_ready;

    // in_ready mirrors "skid entry empty", so an accept never coincides with
    // a skid-to-output move; the skid branch below needs no accept case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else if (w_load) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule : skid_buf
`default_nettype wire

// File: rtl/decoder_3x8_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : decoder_3x8_stream
//  Description : Streaming binary-to-one-hot decoder with valid/ready on both
//                sides, a 2-entry skid buffer, a per-code enable mask and a
//                saturating drop counter for masked codes.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                in_valid/in_ready      - upstream handshake (in_ready reg.)
//                in_code [IN_W]         - code to decode
//                mask [OUT_W]           - mask[k]=1 enables code k
//                out_valid/out_ready    - downstream handshake
//                out_onehot [OUT_W]     - decoded word, zero when idle
//                out_code [IN_W]        - code that produced out_onehot
//                drop_cnt [CNT_W]       - saturating count of masked codes
//                clr_cnt                - synchronous clear of drop_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_3x8_stream
    import decoder_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [(1<<IN_W)-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [(1<<IN_W)-1:0] out_onehot,
    output logic [IN_W-1:0]  out_code,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             clr_cnt
);

    localparam int OUT_W = 1 << IN_W;
    localparam int BUF_W = OUT_W + IN_W;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [OUT_W-1:0] w_onehot;
    logic             w_enabled;
    logic             w_accept;
    logic             w_drop;
    logic [BUF_W-1:0] w_buf_out;
    logic             w_buf_ready;
    logic [CNT_W-1:0] r_drop_cnt;

    generate
        if (IN_W == IN_W_DEF) begin : g_pkg_decode
            assign w_onehot = decode(in_code);
        end else begin : g_shift_decode
            assign w_onehot = OUT_W'(1) << in_code;
        end
    endgenerate

    // Masked codes are still accepted upstream, but never offered to the
    // buffer, so they cannot occupy the skid entry or affect in_ready.
    assign w_enabled = mask[in_code];
    assign w_accept  = in_valid & w_buf_ready;
    assign w_drop    = w_accept & ~w_enabled;

    skid_buf #(
        .WIDTH (BUF_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & w_enabled),
        .in_ready  (w_buf_ready),
        .in_data   ({w_onehot, in_code}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_buf_out)
    );

    // Clear takes priority over a simultaneous drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clr_cnt) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign in_ready   = w_buf_ready;
    assign out_onehot = w_buf_out[BUF_W-1:IN_W];
    assign out_code   = w_buf_out[IN_W-1:0];
    assign drop_cnt   = r_drop_cnt;

endmodule : decoder_3x8_stream
`default_nettype wire
